// File: rtl/hd_frame_decoder.sv
// Streaming Hamming(7,4) frame decoder: corrects single-bit errors per word and
// folds each N_WORD-word frame into one signed result plus an error-word count.
module hd_frame_decoder #(
   parameter int unsigned N_WORD = 4,
   parameter int unsigned OUT_W  = 12,
   parameter int unsigned CNT_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [6:0]       code_word,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_n,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int unsigned WC_W  = (N_WORD > 1) ? $clog2(N_WORD) : 1;
   localparam int unsigned EXT_W = OUT_W - 4;

   // word decode
   logic [2:0] syn_c;
   logic [6:0] flip_c;
   logic [3:0] dat_c;
   logic       flag_c;
   logic       err_c;

   // stage 1
   logic            s1_vld_q, s1_vld_d;
   logic [3:0]      s1_c_q, s1_c_d;
   logic            s1_f_q, s1_f_d;
   logic            s1_e_q, s1_e_d;
   logic            s1_first_q, s1_first_d;
   logic            s1_last_q, s1_last_d;
   logic [WC_W-1:0] wcnt_q, wcnt_d;

   // stage 2 and outputs
   logic [OUT_W-1:0] acc_q, acc_d;
   logic             fprev_q, fprev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_n_q, out_n_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic [OUT_W-1:0] c_ext_c;
   logic [OUT_W-1:0] c_dbl_c;
   logic [OUT_W-1:0] acc_dbl_c;

   always_comb begin
      syn_c = {code_word[6] ^ code_word[3] ^ code_word[2] ^ code_word[1],
               code_word[5] ^ code_word[3] ^ code_word[2] ^ code_word[0],
               code_word[4] ^ code_word[3] ^ code_word[1] ^ code_word[0]};
      flip_c = '0;
      case (syn_c)
         3'b111:  flip_c = 7'b0001000;
         3'b110:  flip_c = 7'b0000100;
         3'b101:  flip_c = 7'b0000010;
         3'b011:  flip_c = 7'b0000001;
         3'b100:  flip_c = 7'b1000000;
         3'b010:  flip_c = 7'b0100000;
         3'b001:  flip_c = 7'b0010000;
         default: flip_c = '0;
      endcase
      dat_c  = code_word[3:0] ^ flip_c[3:0];
      // f is the received value of the bit being corrected
      flag_c = |(code_word & flip_c);
      err_c  = |syn_c;
   end

   always_comb begin
      s1_vld_d   = in_valid;
      s1_c_d     = s1_c_q;
      s1_f_d     = s1_f_q;
      s1_e_d     = s1_e_q;
      s1_first_d = s1_first_q;
      s1_last_d  = s1_last_q;
      wcnt_d     = wcnt_q;
      if (in_valid) begin
         s1_c_d     = dat_c;
         s1_f_d     = flag_c;
         s1_e_d     = err_c;
         s1_first_d = (wcnt_q == '0);
         s1_last_d  = (wcnt_q == WC_W'(N_WORD - 1));
         wcnt_d     = (wcnt_q == WC_W'(N_WORD - 1)) ? '0 : wcnt_q + WC_W'(1);
      end
   end

   assign c_ext_c   = {{EXT_W{s1_c_q[3]}}, s1_c_q};
   assign c_dbl_c   = {c_ext_c[OUT_W-2:0], 1'b0};
   assign acc_dbl_c = {acc_q[OUT_W-2:0], 1'b0};

   always_comb begin
      acc_d       = acc_q;
      fprev_d     = fprev_q;
      cnt_d       = cnt_q;
      out_valid_d = 1'b0;
      out_n_d     = out_n_q;
      err_cnt_d   = err_cnt_q;
      if (s1_vld_q) begin
         if (s1_first_q) begin
            acc_d = c_ext_c;
            cnt_d = CNT_W'(s1_e_q);
         end else begin
            case ({fprev_q, s1_f_q})
               2'b00:   acc_d = acc_dbl_c + c_ext_c;
               2'b01:   acc_d = acc_dbl_c - c_ext_c;
               2'b10:   acc_d = acc_q - c_dbl_c;
               default: acc_d = acc_q + c_dbl_c;
            endcase
            cnt_d = cnt_q + CNT_W'(s1_e_q);
         end
         fprev_d = s1_f_q;
         if (s1_last_q) begin
            out_valid_d = 1'b1;
            out_n_d     = acc_d;
            err_cnt_d   = cnt_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q    <= 1'b0;
         s1_c_q      <= '0;
         s1_f_q      <= 1'b0;
         s1_e_q      <= 1'b0;
         s1_first_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         wcnt_q      <= '0;
         acc_q       <= '0;
         fprev_q     <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_n_q     <= '0;
         err_cnt_q   <= '0;
      end else begin
         s1_vld_q    <= s1_vld_d;
         s1_c_q      <= s1_c_d;
         s1_f_q      <= s1_f_d;
         s1_e_q      <= s1_e_d;
         s1_first_q  <= s1_first_d;
         s1_last_q   <= s1_last_d;
         wcnt_q      <= wcnt_d;
         acc_q       <= acc_d;
         fprev_q     <= fprev_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_n_q     <= out_n_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_n     = out_n_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_hd_frame_decoder.sv
// Scoreboard bench for hd_frame_decoder: three instances (legacy 2x6, 4x6, default)
// share a code-word bus; each has its own in_valid and expected-result queue.
module tb_hd_frame_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] cw;
   logic [2:0] iv;

   logic        ov0, ov1, ov2;
   logic [5:0]  n0, n1;
   logic [11:0] n2;
   logic [3:0]  e0, e1, e2;

   always #5 clk = ~clk;

   hd_frame_decoder #(.N_WORD(2), .OUT_W(6), .CNT_W(4)) u_leg (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .code_word(cw),
      .out_valid(ov0), .out_n(n0), .err_cnt(e0));
   hd_frame_decoder #(.N_WORD(4), .OUT_W(6), .CNT_W(4)) u_n4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .code_word(cw),
      .out_valid(ov1), .out_n(n1), .err_cnt(e1));
   hd_frame_decoder u_def (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .code_word(cw),
      .out_valid(ov2), .out_n(n2), .err_cnt(e2));

   typedef struct {
      logic [11:0] n;
      logic [3:0]  cnt;
      int          cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int m_w[3];
   int m_acc[3];
   int m_err[3];
   bit m_fp[3];
   int ow_of[3] = '{6, 6, 12};
   int nw_of[3] = '{2, 4, 4};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int wrap(input int v, input int ow);
      int r;
      r = v & ((1 << ow) - 1);
      if (r >= (1 << (ow - 1))) r -= (1 << ow);
      return r;
   endfunction

   function automatic bit is_code(input logic [6:0] v);
      return (v[6] == (v[3] ^ v[2] ^ v[1])) &&
             (v[5] == (v[3] ^ v[2] ^ v[0])) &&
             (v[4] == (v[3] ^ v[1] ^ v[0]));
   endfunction

   // brute-force nearest code word: try no flip, then each single flip
   function automatic void dec(input logic [6:0] w, output int c, output bit f, output bit e);
      logic [6:0] v;
      bit found;
      found = 0;
      c = 0; f = 0; e = 0;
      for (int k = -1; k < 7; k++) begin
         v = w;
         if (k >= 0) v[k] = ~v[k];
         if (!found && is_code(v)) begin
            found = 1;
            c = int'(v[3:0]);
            if (v[3]) c -= 16;
            f = (k >= 0) ? w[k] : 1'b0;
            e = (k >= 0);
         end
      end
   endfunction

   function automatic logic [6:0] enc(input logic [3:0] d);
      return {d[3] ^ d[2] ^ d[1], d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0], d};
   endfunction

   function automatic logic [6:0] make_word(input logic [3:0] d, input int k);
      logic [6:0] v;
      v = enc(d);
      if (k >= 0 && k < 7) v[k] = ~v[k];
      return v;
   endfunction

   task automatic send(input int s, input logic [6:0] w);
      int c;
      bit f, e;
      exp_t x;
      dec(w, c, f, e);
      if (m_w[s] == 0) begin
         m_acc[s] = c;
         m_err[s] = int'(e);
      end else begin
         case ({m_fp[s], f})
            2'b00:   m_acc[s] = m_acc[s] * 2 + c;
            2'b01:   m_acc[s] = m_acc[s] * 2 - c;
            2'b10:   m_acc[s] = m_acc[s] - 2 * c;
            default: m_acc[s] = m_acc[s] + 2 * c;
         endcase
         m_err[s] += int'(e);
      end
      m_fp[s]  = f;
      m_acc[s] = wrap(m_acc[s], ow_of[s]);
      @(posedge clk);
      #1;
      iv    = '0;
      iv[s] = 1'b1;
      cw    = w;
      if (m_w[s] == nw_of[s] - 1) begin
         x.n   = 12'(m_acc[s]) & 12'((1 << ow_of[s]) - 1);
         x.cnt = 4'(m_err[s]);
         x.cyc = cyc + 2;
         case (s)
            0:       q0.push_back(x);
            1:       q1.push_back(x);
            default: q2.push_back(x);
         endcase
         m_w[s] = 0;
      end else begin
         m_w[s]++;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         iv = '0;
      end
   endtask

   task automatic check_out(input int s, input logic [11:0] n, input logic [3:0] ec);
      exp_t x;
      int sz;
      sz = (s == 0) ? q0.size() : (s == 1) ? q1.size() : q2.size();
      chk($sformatf("d%0d_pulse_expected", s), int'(sz > 0), 1);
      if (sz > 0) begin
         case (s)
            0:       x = q0.pop_front();
            1:       x = q1.pop_front();
            default: x = q2.pop_front();
         endcase
         chk($sformatf("d%0d_out_n", s), int'(n), int'(x.n));
         chk($sformatf("d%0d_err_cnt", s), int'(ec), int'(x.cnt));
         chk($sformatf("d%0d_latency_cyc", s), cyc, x.cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (ov0 !== 1'b0) check_out(0, {6'b0, n0}, e0);
         if (ov1 !== 1'b0) check_out(1, {6'b0, n1}, e1);
         if (ov2 !== 1'b0) check_out(2, n2, e2);
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_ov0"}, int'(ov0), 0);
      chk({tag, "_n0"}, int'(n0), 0);
      chk({tag, "_e0"}, int'(e0), 0);
      chk({tag, "_ov2"}, int'(ov2), 0);
      chk({tag, "_n2"}, int'(n2), 0);
      chk({tag, "_e2"}, int'(e2), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      iv    = '0;
      cw    = '0;
      for (int s = 0; s < 3; s++) begin
         m_w[s] = 0; m_acc[s] = 0; m_err[s] = 0; m_fp[s] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;
      idle(2);

      // legacy vectors: no errors -> -2/0, single errors -> 19/2
      send(0, 7'b1100011);
      send(0, 7'b1111000);
      send(0, 7'b1101011);
      send(0, 7'b0111000);
      idle(4);

      // every error position (or none) on each word, random data
      for (int k1 = -1; k1 < 7; k1++) begin
         for (int k2 = -1; k2 < 7; k2++) begin
            send(0, make_word(4'($urandom_range(0, 15)), k1));
            send(0, make_word(4'($urandom_range(0, 15)), k2));
         end
      end
      idle(4);

      // 4-word frame with 6-bit wrap: 7, 21, -15, -23
      repeat (4) send(1, 7'b0000111);
      idle(4);

      // default parameters: two back-to-back frames then one with gaps
      repeat (8) send(2, make_word(4'($urandom_range(0, 15)), $urandom_range(0, 7)));
      for (int i = 0; i < 4; i++) begin
         send(2, make_word(4'($urandom_range(0, 15)), $urandom_range(0, 7)));
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      idle(6);

      // abort a frame after 2 words with an asynchronous reset
      send(2, make_word(4'd5, 2));
      send(2, make_word(4'd9, -1));
      idle(1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("async_reset");
      m_w[2] = 0;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      send(2, make_word(4'd3, -1));
      send(2, make_word(4'd12, 6));
      send(2, make_word(4'd7, 3));
      send(2, make_word(4'd1, -1));
      idle(8);

      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      chk("q2_drained", q2.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
